// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_if
// Brief    : Operand/result bundle between the execute stage and the ALU.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       opt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             carry;
    logic             negative;

    modport master (
        output opt, a, b,
        input  out, zero, carry, negative
    );

    modport slave (
        input  opt, a, b,
        output out, zero, carry, negative
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : 32-bit MIPS execute-stage ALU with registered result and flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu #(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_if.slave      bus
);
    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_AND  = 4'd2;
    localparam logic [3:0] c_OP_OR   = 4'd3;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_NOR  = 4'd5;
    localparam logic [3:0] c_OP_MULT = 4'd6;
    localparam logic [3:0] c_OP_SLL  = 4'd7;
    localparam logic [3:0] c_OP_SRL  = 4'd8;
    localparam logic [3:0] c_OP_SRA  = 4'd9;
    localparam logic [3:0] c_OP_LT   = 4'd10;
    localparam logic [3:0] c_OP_GE   = 4'd11;
    localparam logic [3:0] c_OP_EQ   = 4'd12;
    localparam logic [3:0] c_OP_NE   = 4'd13;
    localparam logic [3:0] c_OP_PASS = 4'd14;

    logic [WIDTH:0]            w_add;
    logic [WIDTH:0]            w_sub;
    logic signed [2*WIDTH-1:0] w_prod;
    logic                      w_mul_ovf;
    logic [4:0]                w_shamt;
    logic                      w_lt;
    logic [WIDTH-1:0]          w_result;
    logic                      w_carry;

    // Zero-extended add/sub so the top bit is the unsigned carry / borrow.
    assign w_add   = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub   = {1'b0, bus.a} - {1'b0, bus.b};
    assign w_prod  = $signed({{WIDTH{bus.a[WIDTH-1]}}, bus.a})
                   * $signed({{WIDTH{bus.b[WIDTH-1]}}, bus.b});
    // Overflow when the upper half is not a sign copy of the low half.
    assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
    assign w_shamt = bus.b[4:0];
    assign w_lt    = ($signed(bus.a) < $signed(bus.b));

    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (bus.opt)
            c_OP_ADD:  begin w_result = w_add[WIDTH-1:0]; w_carry = w_add[WIDTH]; end
            c_OP_SUB:  begin w_result = w_sub[WIDTH-1:0]; w_carry = w_sub[WIDTH]; end
            c_OP_AND:  w_result = bus.a & bus.b;
            c_OP_OR:   w_result = bus.a | bus.b;
            c_OP_XOR:  w_result = bus.a ^ bus.b;
            c_OP_NOR:  w_result = ~(bus.a | bus.b);
            c_OP_MULT: begin w_result = w_prod[WIDTH-1:0]; w_carry = w_mul_ovf; end
            c_OP_SLL:  w_result = bus.a << w_shamt;
            c_OP_SRL:  w_result = bus.a >> w_shamt;
            c_OP_SRA:  w_result = $signed(bus.a) >>> w_shamt;
            c_OP_LT:   w_result = {{(WIDTH-1){1'b0}}, w_lt};
            c_OP_GE:   w_result = {{(WIDTH-1){1'b0}}, ~w_lt};
            c_OP_EQ:   w_result = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            c_OP_NE:   w_result = {{(WIDTH-1){1'b0}}, (bus.a != bus.b)};
            c_OP_PASS: w_result = bus.b;
            default:   w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out      <= '0;
            bus.zero     <= 1'b1;
            bus.carry    <= 1'b0;
            bus.negative <= 1'b0;
        end else begin
            bus.out      <= w_result;
            bus.zero     <= (w_result == '0);
            bus.carry    <= w_carry;
            bus.negative <= w_result[WIDTH-1];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Brief    : Self-checking bench for alu: directed cases plus random vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_if #(.WIDTH(32)) bus ();
    alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Present inputs just after an edge, then sample just after the next edge.
    task automatic apply(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        bus.opt = op;
        bus.a   = x;
        bus.b   = y;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] observed();
        return {bus.out, bus.zero, bus.carry, bus.negative};
    endfunction

    // Reference: {result, zero, carry, negative} from arithmetic on wide integers.
    function automatic logic [34:0] model(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [31:0] r;
        logic        c;
        longint      p;
        longint      s;
        r = '0;
        c = 1'b0;
        case (op)
            4'd0: begin
                s = longint'({32'd0, x}) + longint'({32'd0, y});
                r = s[31:0];
                c = (s > 64'sd4294967295);
            end
            4'd1: begin r = x - y; c = (x < y); end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = ~(x | y);
            4'd6: begin
                p = longint'($signed(x)) * longint'($signed(y));
                r = p[31:0];
                c = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            end
            4'd7:  r = x << y[4:0];
            4'd8:  r = x >> y[4:0];
            4'd9:  r = $signed(x) >>> y[4:0];
            4'd10: r = ($signed(x) <  $signed(y)) ? 32'd1 : 32'd0;
            4'd11: r = ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
            4'd12: r = (x == y) ? 32'd1 : 32'd0;
            4'd13: r = (x != y) ? 32'd1 : 32'd0;
            4'd14: r = y;
            default: r = '0;
        endcase
        return {r, (r == 32'd0), c, r[31]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        apply(4'd0, $urandom, $urandom);
        if (observed() !== {32'd0, 3'b100}) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", observed(), {32'd0, 3'b100});
        end
        checks++;
        reset = 1'b0;
    endtask

    task automatic test_add();
        apply(4'd0, 32'd1234, 32'd4321);
        if (observed() !== {32'd5555, 3'b000}) begin
            errors++;
            $display("FAIL add_small got=%h exp=%h", observed(), {32'd5555, 3'b000});
        end
        checks++;
        apply(4'd0, 32'hFFFF_FFFF, 32'd1);
        if (observed() !== {32'd0, 3'b110}) begin
            errors++;
            $display("FAIL add_carry got=%h exp=%h", observed(), {32'd0, 3'b110});
        end
        checks++;
    endtask

    task automatic test_sub();
        apply(4'd1, 32'd1234, 32'd4321);
        if (observed() !== {32'hFFFF_F3F1, 3'b011}) begin
            errors++;
            $display("FAIL sub_borrow got=%h exp=%h", observed(), {32'hFFFF_F3F1, 3'b011});
        end
        checks++;
        apply(4'd1, 32'h8000_0001, 32'd2);
        if (observed() !== {32'h7FFF_FFFF, 3'b000}) begin
            errors++;
            $display("FAIL sub_wrap got=%h exp=%h", observed(), {32'h7FFF_FFFF, 3'b000});
        end
        checks++;
    endtask

    task automatic test_mult();
        apply(4'd6, 32'd12, 32'hFFFF_FFDE);
        if (observed() !== {32'hFFFF_FE68, 3'b001}) begin
            errors++;
            $display("FAIL mult_neg got=%h exp=%h", observed(), {32'hFFFF_FE68, 3'b001});
        end
        checks++;
        apply(4'd6, 32'h4000_0000, 32'd4);
        if (observed() !== {32'd0, 3'b110}) begin
            errors++;
            $display("FAIL mult_ovf got=%h exp=%h", observed(), {32'd0, 3'b110});
        end
        checks++;
    endtask

    task automatic test_compare();
        apply(4'd11, 32'd12, 32'hFFFF_FFDE);
        if (observed() !== {32'd1, 3'b000}) begin
            errors++;
            $display("FAIL comp_ge got=%h exp=%h", observed(), {32'd1, 3'b000});
        end
        checks++;
        apply(4'd10, 32'd12, 32'hFFFF_FFDE);
        if (observed() !== {32'd0, 3'b100}) begin
            errors++;
            $display("FAIL comp_lt got=%h exp=%h", observed(), {32'd0, 3'b100});
        end
        checks++;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [34:0] exp;
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            case ($urandom_range(0, 4))
                0:       y = x;
                1:       y = 32'($urandom_range(0, 40));
                default: y = $urandom;
            endcase
            exp = model(op, x, y);
            apply(op, x, y);
            if (observed() !== exp) begin
                errors++;
                $display("FAIL random op=%0d a=%h b=%h got=%h exp=%h", op, x, y, observed(), exp);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [3];
        logic [31:0] ys [3];
        logic [3:0]  ops [3];
        logic [34:0] prev;
        ops = '{4'd0, 4'd1, 4'd6};
        for (int i = 0; i < 3; i++) begin
            xs[i] = $urandom;
            ys[i] = $urandom;
        end
        prev = observed();
        for (int i = 0; i < 3; i++) begin
            bus.opt = ops[i];
            bus.a   = xs[i];
            bus.b   = ys[i];
            #3;
            if (observed() !== prev) begin
                errors++;
                $display("FAIL b2b_hold%0d got=%h exp=%h", i, observed(), prev);
            end
            checks++;
            @(posedge clk);
            #1;
            prev = model(ops[i], xs[i], ys[i]);
            if (observed() !== prev) begin
                errors++;
                $display("FAIL b2b_op%0d got=%h exp=%h", i, observed(), prev);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        apply(4'd14, 32'd0, 32'hDEAD_BEEF);
        if (observed() !== {32'hDEAD_BEEF, 3'b001}) begin
            errors++;
            $display("FAIL mid_pre got=%h exp=%h", observed(), {32'hDEAD_BEEF, 3'b001});
        end
        checks++;
        reset = 1'b1;
        apply(4'd0, 32'hFFFF_FFFF, 32'd5);
        if (observed() !== {32'd0, 3'b100}) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=%h", observed(), {32'd0, 3'b100});
        end
        checks++;
        reset = 1'b0;
        apply(4'd0, 32'hFFFF_FFFF, 32'd5);
        if (observed() !== {32'd4, 3'b010}) begin
            errors++;
            $display("FAIL mid_resume got=%h exp=%h", observed(), {32'd4, 3'b010});
        end
        checks++;
    endtask

    initial begin
        reset   = 1'b1;
        bus.opt = '0;
        bus.a   = '0;
        bus.b   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_mult();
        test_compare();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
